alu_result_disp: RTL and testbench
==================================

Name: alu_result_disp

Overview:
- Downstream consumer of the ALU's 8-bit result selector.
- Captures the selected 8-bit result on a load strobe and converts it to display digits: unsigned decimal 0–255 via serial double-dabble, or two hex nibbles.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display.
- Sits between the result mux and the board's seg/anode pins.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); minimum 2.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  synchronous, active-low reset
- data_i  in  8  ALU result from the result mux
- load_i  in  1  capture strobe, one cycle
- hex_mode_i  in  1  1 = hex display, 0 = unsigned decimal; sampled with load_i
- busy_o  out  1  conversion in progress; loads ignored while high
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- an_o  out  4  digit anodes, active-low; an_o[0] = rightmost digit

Behaviour:
- Reset, sampled when rst_n_i=0 on a clk_i edge. Reset value of each output and register:
  - FSM returns to IDLE; busy_o=0.
  - Display registers = decimal value 0.
  - Scan counter = 0; digit index = 0.
  - Resulting outputs: an_o=4'b1110, seg_o=7'b1000000 ('0').
  - Reset mid-conversion aborts it; the partial result is discarded.
- FSM states: IDLE, CONV, DONE. busy_o is registered, =1 when state != IDLE.
- IDLE:
  - load_i=1 captures data_i and hex_mode_i and goes to CONV.
  - load_i is ignored in every non-IDLE state, including DONE.
- CONV, decimal:
  - 8 cycles; 4-bit iteration counter 0..7.
  - Each cycle: add 3 to every BCD digit (hundreds, tens, units) >= 5, then shift {bcd,bin} left by 1.
  - After iteration 7, go to DONE.
- CONV, hex: 1 cycle; lo nibble -> digit0, hi nibble -> digit1; go to DONE.
- DONE:
  - Writes digit registers and the mode into the display registers; returns to IDLE.
- Latency, with the load sampled at edge N:
  - Decimal: busy_o=1 for cycles N+1..N+9; new display from N+10.
  - Hex: busy_o=1 for N+1..N+2; new display from N+3.
- Scan:
  - Counter runs 0..REFRESH_DIV-1 continuously. At REFRESH_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0.
  - Display-register updates never reset the scan.
- Digit content, decimal mode:
  - slot0 = units, always lit.
  - slot1 = tens, blank if hundreds=0 and tens=0.
  - slot2 = hundreds, blank if 0.
  - slot3 = blank.
- Digit content, hex mode: slot0 = lo nibble, slot1 = hi nibble, slot2 = blank, slot3 = 'h' (7'b0001011).
- Blank slot: an_o=4'b1111, seg_o=7'b1111111.
- Lit slot: an_o = active-low one-hot of the index; seg_o = glyph.
- seg_o and an_o are registered; they change in the same cycle, so there is no ghosting.
- Glyphs 0–F are the standard hex set: 0=1000000, 2=0100100, 5=0010010, 7=1111000, A=0001000.

Decomposition:
- Package alu_disp_pkg holds:
  - the FSM state encoding (IDLE/CONV/DONE);
  - NUM_DIGITS=4;
  - glyph constants SEG_BLANK and SEG_H;
  - ANODE_OFF=4'b1111.
- One sub-module: seg7_decode, a combinational 4-bit nibble -> 7-bit active-low glyph decoder covering 0–F.

Test Plan (REFRESH_DIV=4 in sim):
- Reset: hold rst_n_i=0 for 2 cycles -> busy_o=0, an_o=4'b1110, seg_o=7'b1000000; index advances every 4 cycles; slots 1–3 show an_o=4'b1111.
- Decimal 255: load_i with data_i=8'd255, hex_mode_i=0 -> busy_o high exactly 9 cycles; then:
  - slot0: an_o=1110, seg_o=0010010
  - slot1: an_o=1101, seg_o=0010010
  - slot2: an_o=1011, seg_o=0100100
  - slot3: an_o=1111
- Hex A7: load_i with data_i=8'hA7, hex_mode_i=1 -> busy_o high 2 cycles; then:
  - slot0: seg_o=1111000
  - slot1: seg_o=0001000
  - slot2: an_o=1111
  - slot3: an_o=0111, seg_o=0001011
- Blanking: decimal 8'd7 -> only slot0 lit ('7'). Decimal 8'd100 -> slots 0 and 1 show '0' (1000000), slot2 shows '1'.
- Load while busy: load 8'd100 at N, load 8'd5 at N+3 and at N+9 (DONE) -> both ignored; display shows 100.
- Reset mid-operation: load 8'd255 at N, rst_n_i=0 at N+4 -> busy_o=0 next cycle; display shows '0'; a fresh load afterwards converts normally.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display block.
// FSM encoding, digit count, fixed glyphs, anode-off value, BCD adjust.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_H     = 7'b0001011;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Double-dabble digit correction applied before each shift.
  function automatic logic [3:0] dd_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment glyph, segments {g,f,e,d,c,b,a}.
// Ports: nib (4-bit value) -> seg (7-bit glyph), purely combinational.
module seg7_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/alu_result_disp.sv
// Captures an ALU result, converts it to decimal (double-dabble) or hex,
// and scans it onto a 4-digit common-anode 7-segment display.
// Ports: clk_i, rst_n_i (sync, active-low), data_i, load_i, hex_mode_i
//        -> busy_o, seg_o {g..a} active-low, an_o active-low (an_o[0] right).
module alu_result_disp
  import alu_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       load_i,
  input  logic       hex_mode_i,
  output logic       busy_o,
  output logic [6:0] seg_o,
  output logic [3:0] an_o
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_t      state;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [3:0]  iter;
  logic        mode;

  logic [11:0] disp;
  logic        disp_hex;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [11:0] adj;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic        lit;
  logic        is_h;
  logic [6:0]  seg_nxt;
  logic [3:0]  an_nxt;

  assign adj = {dd_adj(bcd[11:8]), dd_adj(bcd[7:4]), dd_adj(bcd[3:0])};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      mode     <= 1'b0;
      disp     <= '0;
      disp_hex <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_i) begin
            state  <= CONV;
            busy_o <= 1'b1;
            bin    <= data_i;
            mode   <= hex_mode_i;
            bcd    <= '0;
            iter   <= '0;
          end
        end
        CONV: begin
          if (mode) begin
            bcd   <= {4'h0, bin};
            state <= DONE;
          end else begin
            // Shift the corrected BCD digits and the next binary MSB together.
            bcd  <= {adj[10:0], bin[7]};
            bin  <= {bin[6:0], 1'b0};
            iter <= iter + 4'd1;
            if (iter == 4'd7) state <= DONE;
          end
        end
        DONE: begin
          disp     <= bcd;
          disp_hex <= mode;
          state    <= IDLE;
          busy_o   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Slot content: leading zeros blanked in decimal, fixed 'h' marker in hex.
  always_comb begin
    nib  = 4'h0;
    lit  = 1'b0;
    is_h = 1'b0;
    unique case (idx)
      2'd0: begin
        nib = disp[3:0];
        lit = 1'b1;
      end
      2'd1: begin
        nib = disp[7:4];
        lit = disp_hex || (disp[11:4] != 8'h00);
      end
      2'd2: begin
        nib = disp[11:8];
        lit = !disp_hex && (disp[11:8] != 4'h0);
      end
      2'd3: begin
        lit  = disp_hex;
        is_h = 1'b1;
      end
      default: lit = 1'b0;
    endcase
  end

  seg7_decode u_dec (
    .nib (nib),
    .seg (glyph)
  );

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = ANODE_OFF;
    if (lit) begin
      seg_nxt = is_h ? SEG_H : glyph;
      an_nxt  = ~(4'b0001 << idx);
    end
  end

  // Segments and anodes update on the same edge so no ghosting occurs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      seg_o <= 7'b1000000;
      an_o  <= 4'b1110;
    end else begin
      seg_o <= seg_nxt;
      an_o  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_disp.sv
// Self-checking bench for alu_result_disp with REFRESH_DIV=4.
module tb_alu_result_disp;

  localparam int RD = 4;
  localparam logic [6:0] BLANK_T = 7'b1111111;
  localparam logic [6:0] H_T     = 7'b0001011;
  localparam logic [6:0] GLY [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       load = 1'b0;
  logic       hex = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_disp #(.REFRESH_DIV(RD)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .data_i     (data),
    .load_i     (load),
    .hex_mode_i (hex),
    .busy_o     (busy),
    .seg_o      (seg),
    .an_o       (an)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {lit, glyph} of a slot, from plain arithmetic on the value.
  function automatic logic [7:0] exp_slot(input int v, input bit h,
                                          input int s);
    logic [7:0] r;
    r = {1'b0, BLANK_T};
    if (h) begin
      case (s)
        0: r = {1'b1, GLY[v % 16]};
        1: r = {1'b1, GLY[v / 16]};
        3: r = {1'b1, H_T};
        default: r = {1'b0, BLANK_T};
      endcase
    end else begin
      case (s)
        0: r = {1'b1, GLY[v % 10]};
        1: if (v >= 10) r = {1'b1, GLY[(v / 10) % 10]};
        2: if (v >= 100) r = {1'b1, GLY[v / 100]};
        default: r = {1'b0, BLANK_T};
      endcase
    end
    return r;
  endfunction

  // Observe 16 cycles (one full scan of 4 slots x 4 cycles).
  task automatic check_window(input int v, input bit h, input string tag);
    int cnt [4];
    int blanks;
    int nblank;
    logic [7:0] e;
    cnt = '{0, 0, 0, 0};
    blanks = 0;
    nblank = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an == 4'b1111) begin
        blanks++;
        chk({tag, "_blankseg"}, 16'(seg), 16'(BLANK_T));
      end else begin
        int s;
        s = -1;
        for (int k = 0; k < 4; k++)
          if (an == ~(4'b0001 << k)) s = k;
        if (s < 0) begin
          chk({tag, "_anode"}, 16'(an), 16'(4'b1111));
        end else begin
          cnt[s]++;
          e = exp_slot(v, h, s);
          chk($sformatf("%s_seg%0d", tag, s), 16'(seg), 16'(e[6:0]));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_slot(v, h, k);
      if (!e[7]) nblank++;
      chk($sformatf("%s_cnt%0d", tag, k), 16'(cnt[k]),
          e[7] ? 16'd4 : 16'd0);
    end
    chk({tag, "_blanks"}, 16'(blanks), 16'(4 * nblank));
  endtask

  task automatic do_load(input logic [7:0] d, input bit h,
                         input int exp_busy, input string tag);
    int n;
    @(negedge clk);
    data = d;
    hex  = h;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk({tag, "_busylen"}, 16'(n), 16'(exp_busy));
    @(posedge clk);
  endtask

  initial begin
    int v;
    bit h;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_an", 16'(an), 16'(4'b1110));
    chk("rst_seg", 16'(seg), 16'(7'b1000000));
    check_window(0, 1'b0, "rst");

    do_load(8'd255, 1'b0, 9, "d255");
    check_window(255, 1'b0, "d255");

    do_load(8'hA7, 1'b1, 2, "hA7");
    check_window(8'hA7, 1'b1, "hA7");

    do_load(8'd7, 1'b0, 9, "d7");
    check_window(7, 1'b0, "d7");

    do_load(8'd100, 1'b0, 9, "d100");
    check_window(100, 1'b0, "d100");

    // Loads at N+3 (CONV) and N+9 (DONE) must be ignored.
    @(negedge clk);
    data = 8'd100;
    hex  = 1'b0;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (3) @(negedge clk);
    data = 8'd5;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (6) @(negedge clk);
    chk("lwb_busy_done", 16'(busy), 16'd1);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("lwb_busy_end", 16'(busy), 16'd0);
    @(posedge clk);
    check_window(100, 1'b0, "lwb");
    chk("lwb_busy_after", 16'(busy), 16'd0);

    // Reset at N+4 aborts a decimal conversion.
    @(negedge clk);
    data = 8'd255;
    hex  = 1'b0;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 16'(busy), 16'd0);
    chk("mrst_an", 16'(an), 16'(4'b1110));
    chk("mrst_seg", 16'(seg), 16'(7'b1000000));
    check_window(0, 1'b0, "mrst");

    do_load(8'd42, 1'b0, 9, "d42");
    check_window(42, 1'b0, "d42");

    for (int r = 0; r < 8; r++) begin
      v = int'($urandom_range(0, 255));
      h = 1'($urandom_range(0, 1));
      do_load(8'(v), h, h ? 2 : 9, $sformatf("rnd%0d", r));
      check_window(v, h, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
